load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits directly upstream of the byte-addressed data memory in the MEM stage.
- Accepts one load/store request per handshake from the pipeline and decodes RISC-V funct3 into the memory's access-size code and unsigned flag.
- Range-checks the address, then drives the memory port for one cycle (aligned access) or as a byte-by-byte sequence (misaligned access).
- Returns the load result or a fault on a one-cycle response strobe.

Parameters:
- MEM_BYTES, 4096, memory size in bytes; valid byte range is 0..MEM_BYTES-1.
- SPLIT_MISALIGNED, 1, 1 = misaligned half/word accesses are split into byte accesses; 0 = misaligned accesses fault.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (loads 000/001/010/100/101; stores 000/001/010)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle completion strobe
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  access rejected, memory untouched
- mem_read  out  1  to memory read enable
- mem_write  out  1  to memory write enable
- mem_offset  out  3  access-size code: 001 byte, 010 half, 100 word, 000 idle
- mem_unsigned  out  1  to memory unsigned flag
- mem_addr  out  32  to memory address
- mem_wdata  out  32  to memory write data
- mem_rdata  in  32  from memory; combinational read, valid in the same cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE; resp_valid, resp_fault, mem_read, mem_write, mem_unsigned = 0; resp_rdata, mem_addr, mem_wdata = 0; mem_offset = 000.
- Reset mid-operation: the access aborts immediately. mem_write drops asynchronously and no response is issued.
- FSM states: IDLE, ACCESS, SPLIT, RESP.
- Ready: req_ready = (state == IDLE) && rst_n. req_valid while not ready is ignored.
- Accept (IDLE, req_valid && req_ready): register the address, write data, write flag and decoded fields.
  - size = funct3[1:0]: 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = illegal.
  - unsigned = funct3[2].
- Fault conditions:
  - illegal size;
  - store with funct3[2] = 1;
  - addr + nbytes > MEM_BYTES, computed in 33 bits so 0xFFFFFFFF does not wrap;
  - misaligned access with SPLIT_MISALIGNED = 0.
- IDLE transitions: fault -> RESP with resp_fault = 1. Aligned -> ACCESS. Misaligned -> SPLIT.
- Fault rule: no mem_read or mem_write in any cycle of a faulted request. There are no partial stores.
- ACCESS (exactly 1 cycle):
  - mem_read or mem_write = 1; mem_offset = size code; mem_unsigned = unsigned; mem_addr = addr; mem_wdata = wdata.
  - Load: capture mem_rdata into resp_rdata.
  - Next state: RESP.
- SPLIT (nbytes cycles):
  - Byte counter i = 0..nbytes-1; mem_offset = 001; mem_unsigned = 1; mem_addr = addr + i; mem_wdata[7:0] = wdata byte i.
  - Load: buffer byte i <= mem_rdata[7:0].
  - After the last byte: extend the buffer (signed half uses bit 15 unless unsigned) into resp_rdata, then go to RESP.
- Memory-port idle rule: outside ACCESS/SPLIT, mem_read = mem_write = 0, mem_offset = 000, and mem_addr/mem_wdata = 0. This stops the level-sensitive memory writing garbage.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE.
- Response outputs: resp_rdata and resp_fault are held until the next accept. resp_rdata = 0 for stores and faults.
- Latency from the accept edge N:
  - aligned: resp_valid in cycle N+2;
  - misaligned half: N+3;
  - misaligned word: N+5;
  - fault: N+1.
- Throughput: a new request can be accepted in the cycle after RESP.

Decomposition:
- Package lsu_pkg holds:
  - state enum (IDLE/ACCESS/SPLIT/RESP);
  - memory size codes OFF_BYTE = 3'b001, OFF_HALF = 3'b010, OFF_WORD = 3'b100, OFF_IDLE = 3'b000;
  - funct3 size encodings.
- One sub-module, lsu_load_extend: combinational byte/half/word sign/zero extension of the assembled split-load buffer.

Test Plan:
1. Memory bytes [0..3] = 64 00 00 00; lw (010) at addr 0. Required:
   - mem_read high exactly 1 cycle with mem_offset 100;
   - resp_valid at N+2;
   - resp_rdata 0x00000064, resp_fault 0.
2. Byte 0xC8 at addr 4. Required: lb -> 0xFFFFFFC8; lbu -> 0x000000C8; each read uses mem_offset 001.
3. sw 0xAABBCCDD at addr 1. Required:
   - 4 consecutive mem_write cycles, offset 001, addrs 1,2,3,4, data DD,CC,BB,AA;
   - resp_valid at N+5.
   Then lw at 0 -> 0xBBCCDD64.
4. After scenario 3: lh at addr 3 -> 2 split reads, resp_rdata 0xFFFFAABB; lhu at addr 3 -> 0x0000AABB.
5. Each of these -> resp_fault 1 at N+1, resp_rdata 0, no mem_read/mem_write:
   - lw at 0xFFE;
   - lw at 0xFFFFFFFF;
   - funct3 011;
   - store with funct3 100;
   - lh at 1 with SPLIT_MISALIGNED = 0.
6. Misaligned sw in progress; drop rst_n during the 2nd SPLIT cycle. Required:
   - mem_write 0 immediately;
   - no resp_valid;
   - only byte 1 written;
   - after release req_ready = 1, and the next lw completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store unit.
//   lsu_state_t   : FSM states (IDLE, ACCESS, SPLIT, RESP)
//   OFF_*         : memory access-size codes driven on mem_offset
//   SZ_*          : funct3[1:0] access-size encodings
//   size_nbytes() : byte count for a size encoding
//   size_to_off() : memory access-size code for a size encoding
// ---------------------------------------------------------------------------
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      SPLIT  = 2'd2,
      RESP   = 2'd3
   } lsu_state_t;

   localparam logic [2:0] OFF_IDLE = 3'b000;
   localparam logic [2:0] OFF_BYTE = 3'b001;
   localparam logic [2:0] OFF_HALF = 3'b010;
   localparam logic [2:0] OFF_WORD = 3'b100;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

   // The illegal encoding reports 4 bytes; such requests fault before
   // the count is ever used for a memory access.
   function automatic logic [2:0] size_nbytes(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: return 3'd1;
         SZ_HALF: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [2:0] size_to_off(input logic [1:0] sz);
      case (sz)
         SZ_BYTE: return OFF_BYTE;
         SZ_HALF: return OFF_HALF;
         SZ_WORD: return OFF_WORD;
         default: return OFF_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Bundles the pipeline request/response handshake and the data-memory port.
//   Request : req_valid, req_ready, req_write, req_funct3[2:0], req_addr[31:0],
//             req_wdata[31:0]
//   Response: resp_valid (one-cycle strobe), resp_rdata[31:0], resp_fault
//   Memory  : mem_read, mem_write, mem_offset[2:0], mem_unsigned,
//             mem_addr[31:0], mem_wdata[31:0], mem_rdata[31:0] (combinational)
// Modports:
//   master : the environment (pipeline issuing requests + the data memory)
//   slave  : the load/store unit
// ---------------------------------------------------------------------------
interface load_store_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;

   logic        mem_read;
   logic        mem_write;
   logic [2:0]  mem_offset;
   logic        mem_unsigned;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_fault,
      input  mem_read, mem_write, mem_offset, mem_unsigned, mem_addr, mem_wdata,
      output mem_rdata
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata,
      output req_ready,
      output resp_valid, resp_rdata, resp_fault,
      output mem_read, mem_write, mem_offset, mem_unsigned, mem_addr, mem_wdata,
      input  mem_rdata
   );

endinterface

// File: rtl/load_store_unit_load_extend.sv
// ---------------------------------------------------------------------------
// lsu_load_extend
// Combinational sign/zero extension of an assembled little-endian load buffer.
//   data[31:0]   : assembled bytes, byte 0 in [7:0]
//   size[1:0]    : funct3 size encoding (byte/half/word)
//   is_unsigned  : 1 = zero-extend, 0 = sign-extend
//   result[31:0] : extended load value
// ---------------------------------------------------------------------------
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   logic sign_bit;

   always_comb begin
      sign_bit = 1'b0;
      result   = data;
      case (size)
         SZ_BYTE: begin
            sign_bit = data[7] & ~is_unsigned;
            result   = {{24{sign_bit}}, data[7:0]};
         end
         SZ_HALF: begin
            sign_bit = data[15] & ~is_unsigned;
            result   = {{16{sign_bit}}, data[15:0]};
         end
         default: result = data;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// MEM-stage load/store unit in front of a byte-addressed data memory.
// Accepts one request per handshake, decodes funct3 into the memory size code
// and unsigned flag, range-checks the address and either performs a single
// aligned access or splits a misaligned half/word into byte accesses.
// Parameters:
//   MEM_BYTES        : memory size in bytes (valid bytes 0..MEM_BYTES-1)
//   SPLIT_MISALIGNED : 1 = split misaligned accesses, 0 = fault them
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/response handshake and memory port (slave modport)
// ---------------------------------------------------------------------------
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES        = 4096,
   parameter bit          SPLIT_MISALIGNED = 1'b1
)
(
   input  logic             clk,
   input  logic             rst_n,
   load_store_unit_if.slave bus
);

   lsu_state_t  state_reg, state_next;

   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic        write_reg;
   logic [1:0]  size_reg;
   logic        unsigned_reg;
   logic [1:0]  cnt_reg;
   logic [31:0] buf_reg;
   logic [31:0] resp_rdata_reg;
   logic        resp_fault_reg;

   // ---------------------------------------------------------------- decode
   logic [1:0]  req_size;
   logic [2:0]  req_nbytes;
   logic [32:0] req_end;
   logic        req_oob;
   logic        req_misaligned;
   logic        req_fault;
   logic        accept;

   assign req_size   = bus.req_funct3[1:0];
   assign req_nbytes = size_nbytes(req_size);
   // 33-bit sum so an address near 0xFFFFFFFF cannot wrap back into range.
   assign req_end    = {1'b0, bus.req_addr} + {30'b0, req_nbytes};
   assign req_oob    = req_end > 33'(MEM_BYTES);

   assign req_misaligned = ((req_size == SZ_HALF) && bus.req_addr[0]) ||
                           ((req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

   assign req_fault = (req_size == SZ_ILLEGAL) ||
                      (bus.req_write && bus.req_funct3[2]) ||
                      req_oob ||
                      (req_misaligned && !SPLIT_MISALIGNED);

   assign bus.req_ready = (state_reg == IDLE) && rst_n;
   assign accept        = bus.req_valid && bus.req_ready;

   // ------------------------------------------------------- split datapath
   logic        split_last;
   logic [7:0]  wdata_bytes [4];
   logic [31:0] buf_merged;
   logic [31:0] ext_data;

   assign split_last = ({1'b0, cnt_reg} == (size_nbytes(size_reg) - 3'd1));

   // Byte lanes of the store data, and the load buffer with the byte arriving
   // this cycle already merged in so the last byte feeds the extender directly.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign wdata_bytes[gi]       = wdata_reg[gi*8 +: 8];
         assign buf_merged[gi*8 +: 8] = (cnt_reg == 2'(gi)) ? bus.mem_rdata[7:0]
                                                            : buf_reg[gi*8 +: 8];
      end
   endgenerate

   lsu_load_extend u_load_extend (
      .data        (buf_merged),
      .size        (size_reg),
      .is_unsigned (unsigned_reg),
      .result      (ext_data)
   );

   // -------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // -------------------------------------------- next state and memory port
   // Memory outputs are decoded from the state register, so the async reset
   // forcing IDLE also drops mem_write immediately.
   always_comb begin
      state_next       = state_reg;
      bus.resp_valid   = 1'b0;
      bus.mem_read     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.mem_offset   = OFF_IDLE;
      bus.mem_unsigned = 1'b0;
      bus.mem_addr     = 32'h0;
      bus.mem_wdata    = 32'h0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (req_fault) begin
                  state_next = RESP;
               end else if (req_misaligned) begin
                  state_next = SPLIT;
               end else begin
                  state_next = ACCESS;
               end
            end
         end
         ACCESS: begin
            bus.mem_read     = ~write_reg;
            bus.mem_write    = write_reg;
            bus.mem_offset   = size_to_off(size_reg);
            bus.mem_unsigned = unsigned_reg;
            bus.mem_addr     = addr_reg;
            bus.mem_wdata    = wdata_reg;
            state_next       = RESP;
         end
         SPLIT: begin
            bus.mem_read     = ~write_reg;
            bus.mem_write    = write_reg;
            bus.mem_offset   = OFF_BYTE;
            // Bytes come back raw; extension happens once the word is assembled.
            bus.mem_unsigned = 1'b1;
            bus.mem_addr     = addr_reg + {30'b0, cnt_reg};
            bus.mem_wdata    = {24'b0, wdata_bytes[cnt_reg]};
            if (split_last) begin
               state_next = RESP;
            end
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------ request datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg       <= 32'h0;
         wdata_reg      <= 32'h0;
         write_reg      <= 1'b0;
         size_reg       <= SZ_BYTE;
         unsigned_reg   <= 1'b0;
         cnt_reg        <= 2'd0;
         buf_reg        <= 32'h0;
         resp_rdata_reg <= 32'h0;
         resp_fault_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  addr_reg       <= bus.req_addr;
                  wdata_reg      <= bus.req_wdata;
                  write_reg      <= bus.req_write;
                  size_reg       <= req_size;
                  unsigned_reg   <= bus.req_funct3[2];
                  cnt_reg        <= 2'd0;
                  buf_reg        <= 32'h0;
                  // Stores and faults report zero data; loads overwrite it later.
                  resp_rdata_reg <= 32'h0;
                  resp_fault_reg <= req_fault;
               end
            end
            ACCESS: begin
               if (!write_reg) begin
                  resp_rdata_reg <= bus.mem_rdata;
               end
            end
            SPLIT: begin
               buf_reg <= buf_merged;
               cnt_reg <= cnt_reg + 2'd1;
               if (split_last && !write_reg) begin
                  resp_rdata_reg <= ext_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.resp_rdata = resp_rdata_reg;
   assign bus.resp_fault = resp_fault_reg;

endmodule
